dds_sweep_controller: RTL and testbench

Sequencer that drives the frequency control word (FCW) of a phase-accumulator DDS to produce stepped frequency sweeps (chirps). It latches a sweep configuration on a start pulse, waits for the DDS LUT to report ready, then steps the FCW by a fixed increment, holding each value for a programmable dwell. Supported modes are single sweep, repeating sawtooth and up/down triangle. It sits between the register/control layer and the DDS fcw/enable inputs.

---
 rtl/dds_sweep_controller.sv | 149 ++++++++++++++
 tb/tb_dds_sweep_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_controller.sv
// Stepped-frequency sweep sequencer for a phase-accumulator DDS.
// Latches a sweep config on start, waits for LUT ready, then steps the FCW.
module dds_sweep_controller #(
    parameter int PHASE_WIDTH    = 24,
    parameter int STEP_CNT_WIDTH = 16,
    parameter int DWELL_WIDTH    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [1:0]                mode_i,
    input  logic [PHASE_WIDTH-1:0]    cfg_start_fcw_i,
    input  logic [PHASE_WIDTH-1:0]    cfg_step_i,
    input  logic [STEP_CNT_WIDTH-1:0] cfg_num_steps_i,
    input  logic [DWELL_WIDTH-1:0]    cfg_dwell_i,
    input  logic                      dds_ready_i,
    output logic [PHASE_WIDTH-1:0]    fcw_o,
    output logic                      dds_enable_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [STEP_CNT_WIDTH-1:0] step_idx_o,
    output logic                      dir_down_o,
    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_READY = 2'd1,
        S_RUN        = 2'd2
    } state_t;

    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    localparam logic [DWELL_WIDTH-1:0]    DWELL_ONE = 1;
    localparam logic [STEP_CNT_WIDTH-1:0] IDX_ONE   = 1;

    state_t                    state_q;
    logic [1:0]                mode_q;
    logic [PHASE_WIDTH-1:0]    start_fcw_q;
    logic [PHASE_WIDTH-1:0]    step_q;
    logic [STEP_CNT_WIDTH-1:0] num_steps_q;
    logic [DWELL_WIDTH-1:0]    dwell_q;
    logic [DWELL_WIDTH-1:0]    dwell_cnt_q;
    logic [PHASE_WIDTH-1:0]    fcw_q;
    logic                      enable_q;
    logic                      busy_q;
    logic                      done_q;
    logic [STEP_CNT_WIDTH-1:0] idx_q;
    logic                      dir_down_q;

    // Next FCW for an in-leg step; modulo arithmetic, wrap is intentional.
    logic [PHASE_WIDTH-1:0] fcw_step_d;
    logic                   dwell_end_d;
    logic                   leg_end_d;

    assign fcw_step_d  = dir_down_q ? (fcw_q - step_q) : (fcw_q + step_q);
    assign dwell_end_d = (dwell_cnt_q == dwell_q);
    assign leg_end_d   = (idx_q == num_steps_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            start_fcw_q <= '0;
            step_q      <= '0;
            num_steps_q <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            fcw_q       <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            dir_down_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q  <= S_IDLE;
                enable_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            mode_q      <= mode_i;
                            start_fcw_q <= cfg_start_fcw_i;
                            step_q      <= cfg_step_i;
                            num_steps_q <= cfg_num_steps_i;
                            dwell_q     <= cfg_dwell_i;
                            busy_q      <= 1'b1;
                            state_q     <= S_WAIT_READY;
                        end
                    end
                    S_WAIT_READY: begin
                        if (dds_ready_i) begin
                            fcw_q       <= start_fcw_q;
                            idx_q       <= '0;
                            dwell_cnt_q <= '0;
                            dir_down_q  <= 1'b0;
                            enable_q    <= 1'b1;
                            state_q     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (!dwell_end_d) begin
                            dwell_cnt_q <= dwell_cnt_q + DWELL_ONE;
                        end else begin
                            dwell_cnt_q <= '0;
                            if (!leg_end_d) begin
                                idx_q <= idx_q + IDX_ONE;
                                fcw_q <= fcw_step_d;
                            end else begin
                                case (mode_q)
                                    MODE_REPEAT: begin
                                        fcw_q <= start_fcw_q;
                                        idx_q <= '0;
                                    end
                                    // Turnaround value is held for one more dwell.
                                    MODE_TRIANGLE: begin
                                        dir_down_q <= ~dir_down_q;
                                        idx_q      <= '0;
                                    end
                                    default: begin
                                        enable_q <= 1'b0;
                                        busy_q   <= 1'b0;
                                        done_q   <= 1'b1;
                                        state_q  <= S_IDLE;
                                    end
                                endcase
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign fcw_o        = fcw_q;
    assign dds_enable_o = enable_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign step_idx_o   = idx_q;
    assign dir_down_o   = dir_down_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed bench for dds_sweep_controller: per-cycle vector tables plus
// hand-written sequences for ready gating, abort priority and N=0.
module tb_dds_sweep_controller;

    typedef struct {
        logic        rst;
        logic        start;
        logic        abort;
        logic        ready;
        logic [23:0] fcw;
        logic        en;
        logic        busy;
        logic        done;
        logic [15:0] idx;
        logic        dir;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [23:0] cfg_start_fcw;
    logic [23:0] cfg_step;
    logic [15:0] cfg_num_steps;
    logic [15:0] cfg_dwell;
    logic        dds_ready;
    logic [23:0] fcw;
    logic        dds_enable;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;
    logic        dir_down;
    logic [1:0]  dbg_state;

    int checks;
    int errors;

    vec_t tbl[$];

    dds_sweep_controller #(
        .PHASE_WIDTH(24),
        .STEP_CNT_WIDTH(16),
        .DWELL_WIDTH(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .abort_i(abort),
        .mode_i(mode),
        .cfg_start_fcw_i(cfg_start_fcw),
        .cfg_step_i(cfg_step),
        .cfg_num_steps_i(cfg_num_steps),
        .cfg_dwell_i(cfg_dwell),
        .dds_ready_i(dds_ready),
        .fcw_o(fcw),
        .dds_enable_o(dds_enable),
        .busy_o(busy),
        .done_o(done),
        .step_idx_o(step_idx),
        .dir_down_o(dir_down),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic a, input logic rdy,
                                input logic [23:0] f, input logic e, input logic b,
                                input logic d, input logic [15:0] i, input logic dr);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.ready = rdy;
        v.fcw = f; v.en = e; v.busy = b; v.done = d; v.idx = i; v.dir = dr;
        return v;
    endfunction

    task automatic set_cfg(input logic [1:0] m, input logic [23:0] s, input logic [23:0] st,
                           input logic [15:0] n, input logic [15:0] d);
        mode = m; cfg_start_fcw = s; cfg_step = st; cfg_num_steps = n; cfg_dwell = d;
    endtask

    // drive at negedge, sample 1 time unit after the following posedge
    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; start = v.start; abort = v.abort; dds_ready = v.ready;
        @(posedge clk);
        #1;
        check({tag, "_fcw"},  32'(fcw),        32'(v.fcw));
        check({tag, "_en"},   32'(dds_enable), 32'(v.en));
        check({tag, "_busy"}, 32'(busy),       32'(v.busy));
        check({tag, "_done"}, 32'(done),       32'(v.done));
        check({tag, "_idx"},  32'(step_idx),   32'(v.idx));
        check({tag, "_dir"},  32'(dir_down),   32'(v.dir));
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i], $sformatf("%s%0d", tag, i));
        end
        tbl.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; dds_ready = 1'b0;
        set_cfg(2'd0, 24'h010000, 24'h000100, 16'd3, 16'd1);

        // reset + single sweep, N=3 D=1
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0, 24'h000000, 1'b0,1'b0,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1, 24'h000000, 1'b0,1'b1,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010000, 1'b1,1'b1,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010000, 1'b1,1'b1,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010100, 1'b1,1'b1,1'b0, 16'd1, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010100, 1'b1,1'b1,1'b0, 16'd1, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010200, 1'b1,1'b1,1'b0, 16'd2, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010200, 1'b1,1'b1,1'b0, 16'd2, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010300, 1'b1,1'b1,1'b0, 16'd3, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010300, 1'b1,1'b1,1'b0, 16'd3, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010300, 1'b0,1'b0,1'b1, 16'd3, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h010300, 1'b0,1'b0,1'b0, 16'd3, 1'b0));
        run_table("single");

        // triangle N=2 D=0, then abort mid-run
        set_cfg(2'd2, 24'h000100, 24'h000010, 16'd2, 16'd0);
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1, 24'h010300, 1'b0,1'b1,1'b0, 16'd3, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000100, 1'b1,1'b1,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000110, 1'b1,1'b1,1'b0, 16'd1, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000120, 1'b1,1'b1,1'b0, 16'd2, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000120, 1'b1,1'b1,1'b0, 16'd0, 1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000110, 1'b1,1'b1,1'b0, 16'd1, 1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000100, 1'b1,1'b1,1'b0, 16'd2, 1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000100, 1'b1,1'b1,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000110, 1'b1,1'b1,1'b0, 16'd1, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000120, 1'b1,1'b1,1'b0, 16'd2, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1, 24'h000120, 1'b0,1'b0,1'b0, 16'd2, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000120, 1'b0,1'b0,1'b0, 16'd2, 1'b0));
        run_table("tri");

        // repeat with wrap, start while busy ignored, reset mid-sweep
        set_cfg(2'd1, 24'hFFFFF0, 24'h000010, 16'd1, 16'd0);
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1, 24'h000120, 1'b0,1'b1,1'b0, 16'd2, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'hFFFFF0, 1'b1,1'b1,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000000, 1'b1,1'b1,1'b0, 16'd1, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'hFFFFF0, 1'b1,1'b1,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000000, 1'b1,1'b1,1'b0, 16'd1, 1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1, 24'hFFFFF0, 1'b1,1'b1,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1, 24'h000000, 1'b0,1'b0,1'b0, 16'd0, 1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1, 24'h000000, 1'b0,1'b0,1'b0, 16'd0, 1'b0));
        run_table("wrap");

        // ready gating, then cfg changes and ready drop during RUN are ignored
        set_cfg(2'd0, 24'h010000, 24'h000100, 16'd3, 16'd1);
        @(negedge clk);
        start = 1'b1; dds_ready = 1'b0;
        @(posedge clk); #1;
        check("gate_state", 32'(dbg_state), 32'd1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("gate_busy%0d", i), 32'(busy), 32'd1);
            check($sformatf("gate_en%0d", i), 32'(dds_enable), 32'd0);
            check($sformatf("gate_fcw%0d", i), 32'(fcw), 32'd0);
        end
        @(negedge clk);
        dds_ready = 1'b1;
        @(posedge clk); #1;
        check("gate_load_fcw", 32'(fcw), 32'h010000);
        check("gate_load_en", 32'(dds_enable), 32'd1);
        check("gate_load_state", 32'(dbg_state), 32'd2);
        @(negedge clk);
        dds_ready = 1'b0;
        cfg_step = 24'h000200; cfg_num_steps = 16'd7; cfg_start_fcw = 24'h0;
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) @(negedge clk);
            @(posedge clk); #1;
            check($sformatf("cfgchg_fcw%0d", i), 32'(fcw), 32'h010000 + 32'h100 * (i / 2));
            check($sformatf("cfgchg_idx%0d", i), 32'(step_idx), 32'(i / 2));
            check($sformatf("cfgchg_en%0d", i), 32'(dds_enable), 32'd1);
        end
        @(posedge clk); #1;
        check("cfgchg_done", 32'(done), 32'd1);
        check("cfgchg_en_off", 32'(dds_enable), 32'd0);
        check("cfgchg_busy_off", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("cfgchg_done_pulse", 32'(done), 32'd0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1; dds_ready = 1'b1;
        @(posedge clk); #1;
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("sa_busy2", 32'(busy), 32'd0);
        check("sa_en2", 32'(dds_enable), 32'd0);

        // N=0, D=2 single: one value held 3 cycles
        set_cfg(2'd3, 24'h000ABC, 24'h000001, 16'd0, 16'd2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        check("n0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("n0_fcw%0d", i), 32'(fcw), 32'h000ABC);
            check($sformatf("n0_en%0d", i), 32'(dds_enable), 32'd1);
            check($sformatf("n0_done%0d", i), 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        check("n0_done", 32'(done), 32'd1);
        check("n0_en_off", 32'(dds_enable), 32'd0);
        check("n0_fcw_hold", 32'(fcw), 32'h000ABC);
        check("n0_idx", 32'(step_idx), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
